// File: rtl/fft_pkg.sv
// Shared FFT scheduler types: FSM state encoding and default sizing constants.
package fft_pkg;

  localparam int unsigned N_LOG2_DEF     = 10;
  localparam int unsigned DATA_WIDTH_DEF = 18;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/tw_addr_gen.sv
// Twiddle ROM address for stage s, butterfly k: (k & (2**s - 1)) << (N_LOG2-1-s).
module tw_addr_gen
  import fft_pkg::*;
#(
  parameter int unsigned N_LOG2     = N_LOG2_DEF,
  parameter int unsigned ADDR_WIDTH = N_LOG2 - 1,
  parameter int unsigned S_WIDTH    = $clog2(N_LOG2),
  parameter int unsigned K_WIDTH    = N_LOG2 - 1
) (
  input  logic [S_WIDTH-1:0]    s,
  input  logic [K_WIDTH-1:0]    k,
  output logic [ADDR_WIDTH-1:0] addr
);

  logic [K_WIDTH-1:0] mask;
  logic [S_WIDTH-1:0] shamt;
  logic [K_WIDTH-1:0] full;

  // The shifted index always fits in K_WIDTH bits; at s = K_WIDTH the
  // modular wrap of the shifted one yields an all-ones mask as intended.
  always_comb begin
    mask  = (K_WIDTH'(1) << s) - K_WIDTH'(1);
    shamt = S_WIDTH'(N_LOG2 - 1) - s;
    full  = (k & mask) << shamt;
  end

  assign addr = ADDR_WIDTH'(full);

endmodule

// File: rtl/twiddle_sched.sv
// Radix-2 FFT twiddle scheduler: walks stage/butterfly counters, reads an external
// registered ROM and streams twiddles with valid/ready. Optional macro TW_CONJ_EN
// enables conjugated twiddles for inverse FFT when inv is set at start.
module twiddle_sched
  import fft_pkg::*;
#(
  parameter int unsigned N_LOG2     = N_LOG2_DEF,
  parameter int unsigned ADDR_WIDTH = N_LOG2 - 1,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       inv,
  output logic                       busy,
  output logic                       done,
  output logic                       rom_rd_en,
  output logic [ADDR_WIDTH-1:0]      rom_addr,
  input  logic [DATA_WIDTH-1:0]      rom_real,
  input  logic [DATA_WIDTH-1:0]      rom_imag,
  output logic                       tw_valid,
  input  logic                       tw_ready,
  output logic [DATA_WIDTH-1:0]      tw_real,
  output logic [DATA_WIDTH-1:0]      tw_imag,
  output logic [$clog2(N_LOG2)-1:0]  tw_stage,
  output logic                       tw_last
);

  localparam int unsigned S_WIDTH = $clog2(N_LOG2);
  localparam int unsigned K_WIDTH = N_LOG2 - 1;
  localparam logic [S_WIDTH-1:0] S_LAST = S_WIDTH'(N_LOG2 - 1);
  localparam logic [K_WIDTH-1:0] K_LAST = '1;

  state_t             state;
  logic [S_WIDTH-1:0] s;
  logic [K_WIDTH-1:0] k;
  logic               last_issue;
  logic               accept;

  assign rom_rd_en  = (state == RUN) && (!tw_valid || tw_ready);
  assign last_issue = (s == S_LAST) && (k == K_LAST);
  assign accept     = tw_valid && tw_ready;
  assign done       = (state == DRAIN) && accept && tw_last && !abort;
  assign busy       = (state != IDLE);

  tw_addr_gen #(
    .N_LOG2     (N_LOG2),
    .ADDR_WIDTH (ADDR_WIDTH),
    .S_WIDTH    (S_WIDTH),
    .K_WIDTH    (K_WIDTH)
  ) u_addr_gen (
    .s    (s),
    .k    (k),
    .addr (rom_addr)
  );

  // Sequencer: counters step only on an issued read; sideband tracks the ROM latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      s        <= '0;
      k        <= '0;
      tw_valid <= 1'b0;
      tw_stage <= '0;
      tw_last  <= 1'b0;
    end else if (abort) begin
      state    <= IDLE;
      s        <= '0;
      k        <= '0;
      tw_valid <= 1'b0;
      tw_stage <= '0;
      tw_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= RUN;
        end
        RUN: begin
          if (rom_rd_en) begin
            if (k == K_LAST) begin
              k <= '0;
              if (s == S_LAST) begin
                s     <= '0;
                state <= DRAIN;
              end else begin
                s <= s + S_WIDTH'(1);
              end
            end else begin
              k <= k + K_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (rom_rd_en) begin
        tw_valid <= 1'b1;
        tw_stage <= s;
        tw_last  <= last_issue;
      end else if (tw_ready) begin
        tw_valid <= 1'b0;
        tw_last  <= 1'b0;
      end
    end
  end

  // ROM data is registered and held while no read is issued, so it passes straight through.
  assign tw_real = rom_real;

`ifdef TW_CONJ_EN
  logic inv_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inv_q <= 1'b0;
    end else if (abort) begin
      inv_q <= 1'b0;
    end else if ((state == IDLE) && start) begin
      inv_q <= inv;
    end
  end

  assign tw_imag = inv_q ? ((~rom_imag) + DATA_WIDTH'(1)) : rom_imag;
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign tw_imag    = rom_imag;
`endif

endmodule

// File: tb/tb_twiddle_sched.sv
// Scoreboard bench for twiddle_sched at N_LOG2=3 with a registered ROM model.
module tb_twiddle_sched;

  localparam int unsigned N_LOG2     = 3;
  localparam int unsigned ADDR_WIDTH = 2;
  localparam int unsigned DATA_WIDTH = 18;
  localparam int unsigned N_TW       = 12;
`ifdef TW_CONJ_EN
  localparam bit CONJ = 1'b1;
`else
  localparam bit CONJ = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  start = 1'b0;
  logic                  abort = 1'b0;
  logic                  inv = 1'b0;
  logic                  tw_ready = 1'b1;
  logic [DATA_WIDTH-1:0] rom_real = '0;
  logic [DATA_WIDTH-1:0] rom_imag = '0;
  logic                  busy, done, rom_rd_en, tw_valid, tw_last;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] tw_real, tw_imag;
  logic [1:0]            tw_stage;

  twiddle_sched #(
    .N_LOG2     (N_LOG2),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .inv       (inv),
    .busy      (busy),
    .done      (done),
    .rom_rd_en (rom_rd_en),
    .rom_addr  (rom_addr),
    .rom_real  (rom_real),
    .rom_imag  (rom_imag),
    .tw_valid  (tw_valid),
    .tw_ready  (tw_ready),
    .tw_real   (tw_real),
    .tw_imag   (tw_imag),
    .tw_stage  (tw_stage),
    .tw_last   (tw_last)
  );

  always #5 clk = ~clk;

  // Registered ROM: real encodes the address, imag is a negative ramp.
  always @(posedge clk) begin
    if (rom_rd_en) begin
      rom_real <= 18'h00100 + 18'(rom_addr);
      rom_imag <= 18'h3FFFF - 18'(rom_addr);
    end
  end

  typedef struct packed {
    logic [17:0] re;
    logic [17:0] im;
    logic [1:0]  stage;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   addr_tbl[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
  int   checks = 0;
  int   errors = 0;
  int   n_acc  = 0;
  int   n_done = 0;
  bit   mon_en = 1'b0;

  task automatic push_seq(input bit conj);
    exp_t        e;
    logic [17:0] im_rom;
    for (int i = 0; i < int'(N_TW); i++) begin
      im_rom  = 18'h3FFFF - 18'(addr_tbl[i]);
      e.re    = 18'h00100 + 18'(addr_tbl[i]);
      e.im    = conj ? ((~im_rom) + 18'd1) : im_rom;
      e.stage = 2'(i / 4);
      e.last  = (i == int'(N_TW) - 1);
      sb.push_back(e);
    end
  endtask

  // Scoreboard: every accepted twiddle is popped and compared; done is checked each cycle.
  always @(negedge clk) begin
    exp_t e;
    bit   exp_done;
    if (mon_en) begin
      exp_done = 1'b0;
      if (tw_valid && tw_ready) begin
        n_acc++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: twiddle re=%h stage=%0d accepted, none expected", tw_real, tw_stage);
        end else begin
          e = sb.pop_front();
          exp_done = e.last;
          if ({tw_real, tw_imag, tw_stage, tw_last} !== {e.re, e.im, e.stage, e.last}) begin
            errors++;
            $display("FAIL sb_twiddle: got re=%h im=%h st=%0d last=%b, expected re=%h im=%h st=%0d last=%b",
                     tw_real, tw_imag, tw_stage, tw_last, e.re, e.im, e.stage, e.last);
          end
        end
      end
      if (done) n_done++;
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL done_pulse: got %b expected %b at %0t", done, exp_done, $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      tick();
      cycles++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, expected 0", busy, cycles);
    end
  endtask

  task automatic wait_acc(input int n);
    int c = 0;
    while (n_acc < n && c < 200) begin
      tick();
      c++;
    end
    checks++;
    if (n_acc < n) begin
      errors++;
      $display("FAIL acc_timeout: accepted %0d expected at least %0d", n_acc, n);
    end
  endtask

  task automatic kick(input logic inv_val);
    n_acc  = 0;
    n_done = 0;
    inv    = inv_val;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    inv    = 1'b0;
  endtask

  task automatic check_end(input string name);
    checks++;
    if (n_acc != int'(N_TW) || n_done != 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL %s_end: accepted=%0d done=%0d left=%0d, expected 12/1/0", name, n_acc, n_done, sb.size());
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, done, rom_rd_en, rom_addr, tw_valid, tw_stage, tw_last} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b rd=%b addr=%0d valid=%b stage=%0d last=%b, expected all 0",
               busy, done, rom_rd_en, rom_addr, tw_valid, tw_stage, tw_last);
    end
    tick();
    rst    = 1'b1;
    mon_en = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int cyc;
    sb.delete();
    push_seq(1'b0);
    kick(1'b0);
    checks++;
    if (busy !== 1'b1 || rom_rd_en !== 1'b1 || rom_addr !== 2'd0) begin
      errors++;
      $display("FAIL basic_first_read: busy=%b rd=%b addr=%0d, expected 1 1 0", busy, rom_rd_en, rom_addr);
    end
    wait_idle(cyc);
    checks++;
    if (cyc != 13) begin
      errors++;
      $display("FAIL basic_latency: busy for %0d cycles after start, expected 13", cyc);
    end
    check_end("basic");
  endtask

  task automatic test_back_to_back();
    int cyc;
    push_seq(1'b0);
    kick(1'b0);
    wait_idle(cyc);
    check_end("back_to_back");
  endtask

  task automatic test_stall();
    logic [17:0] re_s, im_s;
    logic [1:0]  st_s;
    logic        last_s;
    int          cyc;
    sb.delete();
    push_seq(1'b0);
    kick(1'b0);
    wait_acc(2);
    tw_ready = 1'b0;
    re_s = tw_real; im_s = tw_imag; st_s = tw_stage; last_s = tw_last;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (tw_valid !== 1'b1 || rom_rd_en !== 1'b0 ||
          {tw_real, tw_imag, tw_stage, tw_last} !== {re_s, im_s, st_s, last_s}) begin
        errors++;
        $display("FAIL stall_hold: cyc=%0d valid=%b rd=%b re=%h im=%h st=%0d, expected 1 0 re=%h im=%h st=%0d",
                 i, tw_valid, rom_rd_en, tw_real, tw_imag, tw_stage, re_s, im_s, st_s);
      end
    end
    tick();
    tw_ready = 1'b1;
    wait_idle(cyc);
    check_end("stall");
  endtask

  task automatic test_abort();
    int cyc;
    sb.delete();
    push_seq(1'b0);
    kick(1'b0);
    wait_acc(5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sb.delete();
    checks++;
    if (tw_valid !== 1'b0 || busy !== 1'b0 || rom_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: valid=%b busy=%b rd=%b, expected 0 0 0", tw_valid, busy, rom_rd_en);
    end
    repeat (5) tick();
    checks++;
    if (n_done != 0) begin
      errors++;
      $display("FAIL abort_no_done: done pulses=%0d expected 0", n_done);
    end
    push_seq(1'b0);
    kick(1'b0);
    wait_idle(cyc);
    check_end("abort_restart");
  endtask

  task automatic test_reset_mid();
    sb.delete();
    push_seq(1'b0);
    kick(1'b0);
    wait_acc(3);
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, rom_rd_en, rom_addr, tw_valid, tw_stage, tw_last} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: busy=%b done=%b rd=%b addr=%0d valid=%b stage=%0d last=%b, expected all 0",
               busy, done, rom_rd_en, rom_addr, tw_valid, tw_stage, tw_last);
    end
    sb.delete();
    tick();
    tick();
    rst    = 1'b1;
    n_done = 0;
    repeat (6) tick();
    checks++;
    if (busy !== 1'b0 || n_done != 0) begin
      errors++;
      $display("FAIL reset_mid_after: busy=%b done pulses=%0d, expected 0 0", busy, n_done);
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    sb.delete();
    push_seq(1'b0);
    kick(1'b0);
    wait_acc(6);
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    wait_idle(cyc);
    check_end("start_ignored");
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_conj();
    int c = 0;
    int cyc;
    sb.delete();
    push_seq(CONJ);
    kick(1'b1);
    while (!tw_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (tw_valid !== 1'b1 || tw_imag !== (CONJ ? 18'h00001 : 18'h3FFFF)) begin
      errors++;
      $display("FAIL conj_first: valid=%b imag=%h expected valid=1 imag=%h",
               tw_valid, tw_imag, (CONJ ? 18'h00001 : 18'h3FFFF));
    end
    wait_idle(cyc);
    check_end("conj");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_abort();
    test_reset_mid();
    test_start_ignored();
    test_conj();
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
